// File: rtl/spibone_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// spibone_wb_arbiter: two-master round-robin Wishbone arbiter with watchdog.
// Rev 1.0
// ---------------------------------------------------------------------------
module spibone_wb_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                      clk48_i,
  input  logic                      reset_ni,

  input  logic [ADDR_WIDTH-1:0]     m0_adr_i,
  input  logic [DATA_WIDTH-1:0]     m0_dat_w_i,
  output logic [DATA_WIDTH-1:0]     m0_dat_r_o,
  input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [2:0]                m0_cti_i,
  input  logic [1:0]                m0_bte_i,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,

  input  logic [ADDR_WIDTH-1:0]     m1_adr_i,
  input  logic [DATA_WIDTH-1:0]     m1_dat_w_i,
  output logic [DATA_WIDTH-1:0]     m1_dat_r_o,
  input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [2:0]                m1_cti_i,
  input  logic [1:0]                m1_bte_i,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,

  output logic [ADDR_WIDTH-1:0]     s_adr_o,
  output logic [DATA_WIDTH-1:0]     s_dat_w_o,
  input  logic [DATA_WIDTH-1:0]     s_dat_r_i,
  output logic [DATA_WIDTH/8-1:0]   s_sel_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,

  output logic [1:0]                grant_o,
  output logic                      timeout_evt_o
);

  localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TIMEOUT_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_M1);
  localparam bit WDOG_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // last_q names the current owner whenever the state is not IDLE.
  logic                    own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0]   own_adr;
  logic [DATA_WIDTH-1:0]   own_dat_w;
  logic [DATA_WIDTH/8-1:0] own_sel;
  logic [2:0]              own_cti;
  logic [1:0]              own_bte;

  assign own_cyc   = last_q ? m1_cyc_i   : m0_cyc_i;
  assign own_stb   = last_q ? m1_stb_i   : m0_stb_i;
  assign own_we    = last_q ? m1_we_i    : m0_we_i;
  assign own_adr   = last_q ? m1_adr_i   : m0_adr_i;
  assign own_dat_w = last_q ? m1_dat_w_i : m0_dat_w_i;
  assign own_sel   = last_q ? m1_sel_i   : m0_sel_i;
  assign own_cti   = last_q ? m1_cti_i   : m0_cti_i;
  assign own_bte   = last_q ? m1_bte_i   : m0_bte_i;

  assign m0_dat_r_o = s_dat_r_i;
  assign m1_dat_r_o = s_dat_r_i;

  always_ff @(posedge clk48_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = '0;
    grant_o       = 2'b00;
    s_adr_o       = '0;
    s_dat_w_o     = '0;
    s_sel_o       = '0;
    s_we_o        = 1'b0;
    s_cti_o       = 3'b000;
    s_bte_o       = 2'b00;
    s_cyc_o       = 1'b0;
    s_stb_o       = 1'b0;
    m0_ack_o      = 1'b0;
    m0_err_o      = 1'b0;
    m1_ack_o      = 1'b0;
    m1_err_o      = 1'b0;
    timeout_evt_o = 1'b0;

    if (state_q != ST_IDLE) begin
      grant_o   = last_q ? 2'b10 : 2'b01;
      s_adr_o   = own_adr;
      s_dat_w_o = own_dat_w;
      s_sel_o   = own_sel;
      s_we_o    = own_we;
      s_cti_o   = own_cti;
      s_bte_o   = own_bte;
    end

    case (state_q)
      ST_IDLE: begin
        // On a tie the master that did not own the bus last wins.
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = ST_GRANT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ST_GRANT1;
          last_d  = 1'b1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        m0_ack_o = s_ack_i & ~last_q;
        m0_err_o = s_err_i & ~last_q;
        m1_ack_o = s_ack_i &  last_q;
        m1_err_o = s_err_i &  last_q;
        if (!own_cyc) begin
          state_d = ST_IDLE;
        end else if (WDOG_EN && own_stb && !s_ack_i && !s_err_i) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_LAST) state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        m0_err_o      = ~last_q;
        m1_err_o      =  last_q;
        timeout_evt_o = 1'b1;
        if (own_cyc) state_d = last_q ? ST_GRANT1 : ST_GRANT0;
        else         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
